fx2_slave_fifo_ctrl: RTL and testbench
======================================

// Module: fx2_slave_fifo_ctrl
// PURPOSE
//  Synthesizable FPGA-side master for the CY68013 slave-FIFO interface.
//  - Moves OUT data (EP2 bulk, EP4 cmd) to one rx stream.
//  - Moves two tx streams to IN endpoints (EP6 bulk, EP8 cmd), with packet commit through pktend.
//  - Round-robin arbitration over the four endpoints; bursts are bounded.
//  - Sits between the fx2_fd pad tristate at top level and the packet/command logic.
// PARAMETERS
//  FD_WIDTH   16   FIFO data bus width (8 or 16)
//  PKT_WORDS  256  IN packet size in words; FX2 auto-commits at this count
//  BURST_MAX  64   max words per grant before re-arbitration (>=1)
//  ADDR_SETUP 1    cycles fifoaddr is held stable before the first strobe (>=1)
// PORTS
//  fx2_ifclk     in   1         interface clock (48 MHz)
//  fx2_rst_n     in   1         async active-low reset
//  fx2_flaga     in   1         EP2 empty (active low)
//  fx2_flagb     in   1         EP4 empty (active low)
//  fx2_flagc     in   1         EP6 full (active low)
//  fx2_flagd     in   1         EP8 full (active low)
//  fx2_slrd      out  1         read strobe (active low)
//  fx2_slwr      out  1         write strobe (active low)
//  fx2_sloe      out  1         FX2 output enable (active low)
//  fx2_pktend    out  1         packet end (active low)
//  fx2_fifoaddr  out  2         00 EP2, 01 EP4, 10 EP6, 11 EP8
//  fd_i          in   FD_WIDTH  fx2_fd pad input
//  fd_o          out  FD_WIDTH  fx2_fd pad output
//  fd_oe         out  1         1 = FPGA drives fx2_fd
//  rx_data       out  FD_WIDTH  word read from the host
//  rx_ep         out  1         source: 0 EP2, 1 EP4
//  rx_valid      out  1         rx word available
//  rx_ready      in   1         consumer accepts rx word
//  tx6_data/tx8_data  in  FD_WIDTH  words for EP6 / EP8
//  tx6_valid/tx8_valid in 1         word available
//  tx6_last/tx8_last   in 1         word ends the packet
//  tx6_ready/tx8_ready out 1        word accepted (equals the slwr strobe)
//  busy          out  1         state != IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; slrd, slwr, sloe, pktend = 1; fifoaddr=00; fd_oe=0; fd_o=0.
//   - rx_valid=0; busy=0; pkt_cnt6=pkt_cnt8=0; rr_ptr=0.
//  States: IDLE -> SEL -> {RD_OE->RD | WR} -> [PKTEND] -> TURN -> IDLE.
//  IDLE:
//   - Request per endpoint: EP2 = flaga=1; EP4 = flagb=1; EP6 = flagc=1 & tx6_valid; EP8 = flagd=1 & tx8_valid.
//   - Grant the first request at or after rr_ptr; rr_ptr <= grant+1 (mod 4).
//   - No request: stay in IDLE.
//  SEL: drive fifoaddr=grant; wait ADDR_SETUP cycles; fifoaddr holds until TURN exits.
//  RD_OE: sloe=0 for one cycle before any slrd.
//  RD:
//   - slrd is combinational: 0 iff flag nonempty & (~rx_valid | rx_ready) & burst<BURST_MAX.
//   - On each edge with slrd=0: rx_data<=fd_i, rx_ep<=fifoaddr[0], rx_valid<=1.
//   - rx_valid clears on rx_ready when no new word is captured.
//   - Exit to TURN when the flag reads empty or burst=BURST_MAX. rx_valid may remain set.
//  WR:
//   - fd_oe=1; fd_o=tx data.
//   - slwr=tx_ready=0/1 iff flag not full & tx_valid & burst<BURST_MAX.
//   - Each written word: pkt_cnt++. At PKT_WORDS, pkt_cnt<=0 (FX2 auto-commits; no pktend).
//   - Word with last=1 and pkt_cnt+1<PKT_WORDS: go to PKTEND. Otherwise last ends the burst (-> TURN).
//   - Exit to TURN when full, tx_valid=0, or burst limit reached.
//  PKTEND: pktend=0 for exactly one cycle; pkt_cnt<=0; fd_oe stays 1.
//  TURN: one cycle with sloe=1 and fd_oe=0; fd_oe and sloe are never both active.
//  Boundary conditions:
//   - No strobe is issued in SEL, RD_OE, PKTEND or TURN.
//   - slrd and slwr are never both 0.
//   - The burst counter clears in SEL; width is clog2(BURST_MAX+1).
//   - Flag change mid-burst stops strobes on the same cycle (combinational qualification).
//   - Reset mid-burst releases all strobes and the bus immediately. Partial packet counts are discarded.
// TESTING (bench: fx2_sim-compatible FIFO model, 16-bit)
//  1 Load EP4 with 0x6548,0x6c6c,0x006f; rx_ready=1 -> rx gets those 3 words with rx_ep=1; 3 slrd pulses; flagb low after.
//  2 tx6: 4 words, last on word 4 -> 4 slwr on addr 10, then one pktend pulse; pkt_cnt6=0.
//  3 tx6 streams PKT_WORDS=256 words, last on 256 -> no pktend; a second burst is split by BURST_MAX=64 (4 grants).
//  4 EP2, EP4, EP6 all requesting -> grants rotate EP2, EP4, EP6; rx_ready=0 holds slrd high, data is not lost.
//  5 Model asserts flagc (full) after 10 words -> slwr rises that cycle; resumes after flag clears, no duplicate word.
//  6 Assert fx2_rst_n=0 during a WR burst -> strobes=1 and fd_oe=0 before the next edge; IDLE after release.

Source files
------------

// File: rtl/fx2_slave_fifo_ctrl.sv
// FPGA-side master for the CY68013 slave-FIFO interface: drains EP2/EP4 into one
// rx stream and feeds two tx streams into EP6/EP8, with round-robin bounded bursts.
module fx2_slave_fifo_ctrl #(
  parameter int FD_WIDTH   = 16,
  parameter int PKT_WORDS  = 256,
  parameter int BURST_MAX  = 64,
  parameter int ADDR_SETUP = 1
) (
  input  logic                fx2_ifclk,
  input  logic                fx2_rst_n,
  input  logic                fx2_flaga,
  input  logic                fx2_flagb,
  input  logic                fx2_flagc,
  input  logic                fx2_flagd,
  output logic                fx2_slrd,
  output logic                fx2_slwr,
  output logic                fx2_sloe,
  output logic                fx2_pktend,
  output logic [1:0]          fx2_fifoaddr,
  input  logic [FD_WIDTH-1:0] fd_i,
  output logic [FD_WIDTH-1:0] fd_o,
  output logic                fd_oe,
  output logic [FD_WIDTH-1:0] rx_data,
  output logic                rx_ep,
  output logic                rx_valid,
  input  logic                rx_ready,
  input  logic [FD_WIDTH-1:0] tx6_data,
  input  logic                tx6_valid,
  input  logic                tx6_last,
  output logic                tx6_ready,
  input  logic [FD_WIDTH-1:0] tx8_data,
  input  logic                tx8_valid,
  input  logic                tx8_last,
  output logic                tx8_ready,
  output logic                busy
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam int SW = $clog2(ADDR_SETUP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_RD_OE, S_RD, S_WR, S_PKTEND, S_TURN
  } state_t;

  state_t              state_q;
  logic [1:0]          fifoaddr_q;
  logic [1:0]          rr_ptr_q;
  logic                sloe_q;
  logic                pktend_q;
  logic                fd_oe_q;
  logic                rx_valid_q;
  logic [FD_WIDTH-1:0] rx_data_q;
  logic                rx_ep_q;
  logic [BW-1:0]       burst_q;
  logic [SW-1:0]       setup_q;
  logic [PW-1:0]       pkt_cnt6_q;
  logic [PW-1:0]       pkt_cnt8_q;

  logic                flag_sel;
  logic                tx_valid_sel;
  logic                tx_last_sel;
  logic [FD_WIDTH-1:0] tx_data_sel;
  logic [PW-1:0]       pkt_cnt_sel;
  logic [PW-1:0]       pkt_inc_d;
  logic                pkt_full_d;
  logic [BW-1:0]       burst_inc_d;
  logic                burst_ok;
  logic                burst_last_d;
  logic                rd_stb;
  logic                wr_stb;
  logic [3:0]          req_d;
  logic [1:0]          grant_d;
  logic                grant_vld_d;

  always_comb begin
    case (fifoaddr_q)
      2'd0:    flag_sel = fx2_flaga;
      2'd1:    flag_sel = fx2_flagb;
      2'd2:    flag_sel = fx2_flagc;
      default: flag_sel = fx2_flagd;
    endcase
  end

  assign tx_valid_sel = fifoaddr_q[0] ? tx8_valid  : tx6_valid;
  assign tx_last_sel  = fifoaddr_q[0] ? tx8_last   : tx6_last;
  assign tx_data_sel  = fifoaddr_q[0] ? tx8_data   : tx6_data;
  assign pkt_cnt_sel  = fifoaddr_q[0] ? pkt_cnt8_q : pkt_cnt6_q;
  assign pkt_inc_d    = pkt_cnt_sel + PW'(1);
  assign pkt_full_d   = (pkt_inc_d == PW'(PKT_WORDS));
  assign burst_inc_d  = burst_q + BW'(1);
  assign burst_ok     = (burst_q < BW'(BURST_MAX));
  assign burst_last_d = (burst_inc_d == BW'(BURST_MAX));

  // Strobes are qualified combinationally so a flag change stops them in the same cycle.
  assign rd_stb = (state_q == S_RD) && flag_sel && (!rx_valid_q || rx_ready) && burst_ok;
  assign wr_stb = (state_q == S_WR) && flag_sel && tx_valid_sel && burst_ok;

  assign fx2_slrd     = !rd_stb;
  assign fx2_slwr     = !wr_stb;
  assign fx2_sloe     = sloe_q;
  assign fx2_pktend   = pktend_q;
  assign fx2_fifoaddr = fifoaddr_q;
  assign fd_oe        = fd_oe_q;
  assign fd_o         = fd_oe_q ? tx_data_sel : '0;
  assign tx6_ready    = wr_stb && !fifoaddr_q[0];
  assign tx8_ready    = wr_stb && fifoaddr_q[0];
  assign rx_data      = rx_data_q;
  assign rx_ep        = rx_ep_q;
  assign rx_valid     = rx_valid_q;
  assign busy         = (state_q != S_IDLE);

  assign req_d = {fx2_flagd & tx8_valid, fx2_flagc & tx6_valid, fx2_flagb, fx2_flaga};

  // Scan downwards so the request closest to rr_ptr is the one left standing.
  always_comb begin
    grant_d     = rr_ptr_q;
    grant_vld_d = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req_d[rr_ptr_q + 2'(i)]) begin
        grant_d     = rr_ptr_q + 2'(i);
        grant_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge fx2_ifclk or negedge fx2_rst_n) begin
    if (!fx2_rst_n) begin
      state_q    <= S_IDLE;
      fifoaddr_q <= 2'd0;
      rr_ptr_q   <= 2'd0;
      sloe_q     <= 1'b1;
      pktend_q   <= 1'b1;
      fd_oe_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      burst_q    <= '0;
      setup_q    <= '0;
      pkt_cnt6_q <= '0;
      pkt_cnt8_q <= '0;
    end else begin
      if (rd_stb) begin
        rx_valid_q <= 1'b1;
      end else if (rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_vld_d) begin
            fifoaddr_q <= grant_d;
            rr_ptr_q   <= grant_d + 2'd1;
            setup_q    <= '0;
            state_q    <= S_SEL;
          end
        end
        S_SEL: begin
          burst_q <= '0;
          if (setup_q == SW'(ADDR_SETUP - 1)) begin
            if (fifoaddr_q[1]) begin
              fd_oe_q <= 1'b1;
              state_q <= S_WR;
            end else begin
              sloe_q  <= 1'b0;
              state_q <= S_RD_OE;
            end
          end else begin
            setup_q <= setup_q + SW'(1);
          end
        end
        S_RD_OE: state_q <= S_RD;
        S_RD: begin
          if (rd_stb) begin
            burst_q <= burst_inc_d;
          end
          if (!flag_sel || !burst_ok || (rd_stb && burst_last_d)) begin
            sloe_q  <= 1'b1;
            state_q <= S_TURN;
          end
        end
        S_WR: begin
          if (wr_stb) begin
            burst_q <= burst_inc_d;
            // A full packet is committed by the FX2 itself, so the count wraps here.
            if (fifoaddr_q[0]) begin
              pkt_cnt8_q <= pkt_full_d ? '0 : pkt_inc_d;
            end else begin
              pkt_cnt6_q <= pkt_full_d ? '0 : pkt_inc_d;
            end
            if (tx_last_sel && !pkt_full_d) begin
              pktend_q <= 1'b0;
              state_q  <= S_PKTEND;
            end else if (tx_last_sel || burst_last_d) begin
              fd_oe_q <= 1'b0;
              state_q <= S_TURN;
            end
          end else begin
            fd_oe_q <= 1'b0;
            state_q <= S_TURN;
          end
        end
        S_PKTEND: begin
          pktend_q <= 1'b1;
          fd_oe_q  <= 1'b0;
          if (fifoaddr_q[0]) begin
            pkt_cnt8_q <= '0;
          end else begin
            pkt_cnt6_q <= '0;
          end
          state_q <= S_TURN;
        end
        S_TURN:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Captured word carries no reset: rx_valid alone says whether it means anything.
  always_ff @(posedge fx2_ifclk) begin
    if (rd_stb) begin
      rx_data_q <= fd_i;
      rx_ep_q   <= fifoaddr_q[0];
    end
  end

endmodule

// File: tb/tb_fx2_slave_fifo_ctrl.sv
// Bench for fx2_slave_fifo_ctrl: FX2 FIFO model, tx producers and an rx consumer,
// with per-endpoint scoreboards filled when stimulus is issued.
module tb_fx2_slave_fifo_ctrl;
  localparam int W   = 16;
  localparam int PKT = 256;
  localparam int BM  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         flaga = 0, flagb = 0, flagc = 0, flagd = 0;
  logic         slrd, slwr, sloe, pktend, fd_oe, busy;
  logic [1:0]   fifoaddr;
  logic [W-1:0] fd_i = '0, fd_o, rx_data;
  logic         rx_ep, rx_valid, rx_ready = 1'b1;
  logic [W-1:0] tx6_data = '0, tx8_data = '0;
  logic         tx6_valid = 0, tx8_valid = 0, tx6_last = 0, tx8_last = 0;
  logic         tx6_ready, tx8_ready;

  fx2_slave_fifo_ctrl #(.FD_WIDTH(W), .PKT_WORDS(PKT), .BURST_MAX(BM), .ADDR_SETUP(1)) dut (
    .fx2_ifclk(clk), .fx2_rst_n(rst_n),
    .fx2_flaga(flaga), .fx2_flagb(flagb), .fx2_flagc(flagc), .fx2_flagd(flagd),
    .fx2_slrd(slrd), .fx2_slwr(slwr), .fx2_sloe(sloe), .fx2_pktend(pktend),
    .fx2_fifoaddr(fifoaddr), .fd_i(fd_i), .fd_o(fd_o), .fd_oe(fd_oe),
    .rx_data(rx_data), .rx_ep(rx_ep), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx6_data(tx6_data), .tx6_valid(tx6_valid), .tx6_last(tx6_last), .tx6_ready(tx6_ready),
    .tx8_data(tx8_data), .tx8_valid(tx8_valid), .tx8_last(tx8_last), .tx8_ready(tx8_ready),
    .busy(busy)
  );

  typedef struct packed { logic last; logic [W-1:0] data; } txw_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [W-1:0] host2[$], host4[$];     // OUT endpoint contents seen by the FPGA
  logic [W-1:0] exp_rx0[$], exp_rx1[$]; // expected rx words per source
  txw_t prod6[$], prod8[$];             // tx producer queues
  txw_t exp6[$], exp8[$];               // expected IN words; .last = packet commits after it
  int   ecnt[2];                        // reference words-since-commit per IN endpoint
  int   fcnt[2];                        // FX2-side words in the open packet
  bit   pend[2];                        // a commit is owed for the last word written
  int   rd_cnt[2], wr_cnt[2], pktend_cnt;
  int   grants[$];
  bit   busy_prev = 1'b0;
  bit   rdy_rand = 0, gap_rand = 0, flag_rand = 0;
  int   hold_c = 0, full_trig = -1, c6_words = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic load_out(input int ep, input logic [W-1:0] v);
    if (ep == 0) begin host2.push_back(v); exp_rx0.push_back(v); end
    else         begin host4.push_back(v); exp_rx1.push_back(v); end
  endtask

  // Reference: a packet commits after the PKT-th word since the last commit, or on 'last'.
  task automatic push_tx(input int ep, input int n, input bit with_last);
    txw_t w, e;
    for (int i = 0; i < n; i++) begin
      w.data = W'($urandom);
      w.last = with_last && (i == n - 1);
      ecnt[ep]++;
      e.data = w.data;
      e.last = (ecnt[ep] == PKT) || w.last;
      if (e.last) ecnt[ep] = 0;
      if (ep == 0) begin prod6.push_back(w); exp6.push_back(e); end
      else         begin prod8.push_back(w); exp8.push_back(e); end
    end
  endtask

  function automatic bit all_drained();
    return host2.size() == 0 && host4.size() == 0 && prod6.size() == 0 &&
           prod8.size() == 0 && !busy && !rx_valid;
  endfunction

  task automatic wait_idle(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      step();
      if (all_drained()) break;
    end
    chk(name, i < max, 1);
  endtask

  // FX2 + producer/consumer model: drive at negedge, commit handshakes seen just after.
  initial forever begin
    @(negedge clk);
    flaga = host2.size() != 0;
    flagb = host4.size() != 0;
    if (hold_c > 0) begin
      flagc = 1'b0;
      hold_c--;
    end else begin
      flagc = !flag_rand || ($urandom_range(7) != 0);
    end
    flagd = !flag_rand || ($urandom_range(7) != 0);
    if (fifoaddr == 2'd0 && host2.size() != 0)      fd_i = host2[0];
    else if (fifoaddr == 2'd1 && host4.size() != 0) fd_i = host4[0];
    else                                            fd_i = '0;
    tx6_valid = prod6.size() != 0 && (!gap_rand || $urandom_range(7) != 0);
    tx6_data  = prod6.size() != 0 ? prod6[0].data : '0;
    tx6_last  = prod6.size() != 0 ? prod6[0].last : 1'b0;
    tx8_valid = prod8.size() != 0 && (!gap_rand || $urandom_range(7) != 0);
    tx8_data  = prod8.size() != 0 ? prod8[0].data : '0;
    tx8_last  = prod8.size() != 0 ? prod8[0].last : 1'b0;
    rx_ready  = !rdy_rand || ($urandom_range(1) == 1);
    #1;
    if (rst_n) begin
      if (!slrd && fifoaddr == 2'd0 && host2.size() != 0) void'(host2.pop_front());
      if (!slrd && fifoaddr == 2'd1 && host4.size() != 0) void'(host4.pop_front());
      if (tx6_ready && prod6.size() != 0) begin
        void'(prod6.pop_front());
        c6_words++;
        if (c6_words == full_trig) hold_c = 6;
      end
      if (tx8_ready && prod8.size() != 0) void'(prod8.pop_front());
    end
  end

  // Monitor: protocol rules every cycle, scoreboards on every handshake.
  initial forever begin
    logic cur_flag;
    txw_t e;
    int   ep;
    @(negedge clk);
    #1;
    if (rst_n) begin
      case (fifoaddr)
        2'd0: cur_flag = flaga;
        2'd1: cur_flag = flagb;
        2'd2: cur_flag = flagc;
        default: cur_flag = flagd;
      endcase
      chk("strobe_exclusive", {31'd0, !slrd && !slwr}, 0);
      chk("oe_exclusive", {31'd0, fd_oe && !sloe}, 0);
      chk("rd_flag_qual", {31'd0, !slrd && (!cur_flag || fifoaddr[1] || sloe)}, 0);
      chk("wr_flag_qual", {31'd0, !slwr && (!cur_flag || !fifoaddr[1] || !fd_oe)}, 0);
      chk("tx6_ready", {31'd0, tx6_ready}, {31'd0, !slwr && fifoaddr == 2'd2});
      chk("tx8_ready", {31'd0, tx8_ready}, {31'd0, !slwr && fifoaddr == 2'd3});
      if (rx_valid && !rx_ready) chk("rd_stall", {31'd0, slrd}, 1);
      if (!busy_prev && busy) grants.push_back(int'(fifoaddr));
      busy_prev = busy;
      if (!slrd) rd_cnt[fifoaddr[0]]++;
      if (rx_valid && rx_ready) begin
        if (!rx_ep && exp_rx0.size() != 0)     chk("rx_data_ep2", rx_data, exp_rx0.pop_front());
        else if (rx_ep && exp_rx1.size() != 0) chk("rx_data_ep4", rx_data, exp_rx1.pop_front());
        else chk("rx_unexpected_word", {31'd0, rx_ep}, 32'hffff_ffff);
      end
      if (!slwr) begin
        ep = int'(fifoaddr[0]);
        wr_cnt[ep]++;
        chk("missing_commit", {31'd0, pend[ep]}, 0);
        if (ep == 0 && exp6.size() != 0)      e = exp6.pop_front();
        else if (ep == 1 && exp8.size() != 0) e = exp8.pop_front();
        else begin
          e = '0;
          chk("wr_unexpected_word", fd_o, 32'hffff_ffff);
        end
        chk("wr_data", fd_o, e.data);
        pend[ep] = e.last;
        fcnt[ep]++;
        if (fcnt[ep] == PKT) begin
          chk("auto_commit_boundary", {31'd0, pend[ep]}, 1);
          pend[ep] = 1'b0;
          fcnt[ep] = 0;
        end
      end
      if (!pktend) begin
        ep = int'(fifoaddr[0]);
        pktend_cnt++;
        chk("pktend_addr", {31'd0, fifoaddr[1]}, 1);
        chk("pktend_nonempty", {31'd0, fcnt[ep] != 0}, 1);
        chk("pktend_boundary", {31'd0, pend[ep]}, 1);
        pend[ep] = 1'b0;
        fcnt[ep] = 0;
      end
    end
  end

  initial begin
    int b0, w0, p0, g0, i;
    step();
    step();
    chk("rst_slrd", {31'd0, slrd}, 1);
    chk("rst_slwr", {31'd0, slwr}, 1);
    chk("rst_sloe", {31'd0, sloe}, 1);
    chk("rst_pktend", {31'd0, pktend}, 1);
    chk("rst_fifoaddr", {30'd0, fifoaddr}, 0);
    chk("rst_fd_oe", {31'd0, fd_oe}, 0);
    chk("rst_fd_o", {16'd0, fd_o}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    step();

    // Three words from EP4.
    b0 = rd_cnt[1];
    load_out(1, 16'h6548);
    load_out(1, 16'h6c6c);
    load_out(1, 16'h006f);
    wait_idle("t1_idle", 200);
    chk("t1_reads", rd_cnt[1] - b0, 3);
    chk("t1_rx_left", exp_rx1.size(), 0);

    // Short EP6 packet ends with pktend.
    w0 = wr_cnt[0]; p0 = pktend_cnt;
    push_tx(0, 4, 1);
    wait_idle("t2_idle", 200);
    chk("t2_writes", wr_cnt[0] - w0, 4);
    chk("t2_pktend", pktend_cnt - p0, 1);

    // Full-size packet: auto commit, split into BURST_MAX grants.
    w0 = wr_cnt[0]; p0 = pktend_cnt; g0 = grants.size();
    push_tx(0, PKT, 1);
    wait_idle("t3_idle", 2000);
    chk("t3_writes", wr_cnt[0] - w0, PKT);
    chk("t3_no_pktend", pktend_cnt - p0, 0);
    chk("t3_grants", grants.size() - g0, PKT / BM);

    // All three requesting at once: rotation continues from EP2; slow consumer.
    g0 = grants.size();
    rdy_rand = 1;
    for (int k = 0; k < 5; k++) begin
      load_out(0, W'($urandom));
      load_out(1, W'($urandom));
    end
    push_tx(0, 5, 1);
    wait_idle("t4_idle", 1000);
    rdy_rand = 0;
    chk("t4_grant_count", grants.size() - g0, 3);
    if (grants.size() - g0 >= 3) begin
      chk("t4_grant0", grants[g0], 0);
      chk("t4_grant1", grants[g0 + 1], 1);
      chk("t4_grant2", grants[g0 + 2], 2);
    end

    // EP6 goes full after 10 words mid-burst.
    w0 = wr_cnt[0]; p0 = pktend_cnt;
    full_trig = c6_words + 10;
    push_tx(0, 20, 1);
    wait_idle("t5_idle", 500);
    chk("t5_writes", wr_cnt[0] - w0, 20);
    chk("t5_pktend", pktend_cnt - p0, 1);

    // Reset during a write burst.
    w0 = wr_cnt[0];
    push_tx(0, 40, 0);
    for (i = 0; i < 200 && (wr_cnt[0] - w0) < 5; i++) step();
    chk("t6_burst_started", i < 200, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_slwr", {31'd0, slwr}, 1);
    chk("t6_slrd", {31'd0, slrd}, 1);
    chk("t6_pktend", {31'd0, pktend}, 1);
    chk("t6_sloe", {31'd0, sloe}, 1);
    chk("t6_fd_oe", {31'd0, fd_oe}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    prod6.delete();
    exp6.delete();
    ecnt[0] = 0; fcnt[0] = 0; pend[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t6_idle_after", {31'd0, busy}, 0);
    busy_prev = 1'b0;

    // Randomized traffic on all four endpoints.
    rdy_rand = 1; gap_rand = 1; flag_rand = 1;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(3))
        0: for (int k = $urandom_range(80, 1); k > 0; k--) load_out(0, W'($urandom));
        1: for (int k = $urandom_range(80, 1); k > 0; k--) load_out(1, W'($urandom));
        2: push_tx(0, $urandom_range(300, 1), $urandom_range(3) != 0);
        default: push_tx(1, $urandom_range(300, 1), $urandom_range(3) != 0);
      endcase
      repeat ($urandom_range(40)) step();
    end
    wait_idle("rand_idle", 40000);
    rdy_rand = 0; gap_rand = 0; flag_rand = 0;
    chk("end_rx0_left", exp_rx0.size(), 0);
    chk("end_rx1_left", exp_rx1.size(), 0);
    chk("end_exp6_left", exp6.size(), 0);
    chk("end_exp8_left", exp8.size(), 0);
    chk("end_pend6", {31'd0, pend[0]}, 0);
    chk("end_pend8", {31'd0, pend[1]}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
